instr_fetch_queue: RTL and testbench
====================================

# instr_fetch_queue

Prefetch queue between the instruction memory port and the IF/ID pipeline registers of the pipelined CPU. It fetches sequential instructions from a variable-latency memory over a req/ack handshake and buffers up to DEPTH {instruction, PC+4} pairs. It presents the head entry to IF/ID, which pops it when IF/ID is write-enabled. On a taken-branch redirect from EX/MEM it discards all buffered and in-flight words and restarts fetching at the branch target.

## Interface
- DEPTH, 4: queue entries; power of two, at least 2
- RESET_PC, 32'h0000_0000: first fetch address after reset
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset, synchronous, active-high
- redirect_i  in  1  taken branch (EX/MEM Branch & zero)
- redirect_pc_i  in  32  branch target; sampled when redirect_i=1
- mem_req_o  out  1  fetch request, registered
- mem_addr_o  out  32  fetch address, registered; stable while mem_req_o=1
- mem_ack_i  in  1  memory returns mem_data_i this cycle; meaningful only while mem_req_o=1
- mem_data_i  in  32  fetched instruction
- deq_ready_i  in  1  IF/ID write enable (0 = load-use stall)
- deq_valid_o  out  1  head entry valid
- deq_instr_o  out  32  head instruction; 0 when empty
- deq_pc_o  out  32  head address + 4; 0 when empty
- level_o  out  $clog2(DEPTH+1)  occupied entries

## Operation
- State: fetch_pc, circular FIFO (wr_ptr, rd_ptr, count), FSM {IDLE, REQ, DRAIN}, pending_pc.
- IDLE: if count<DEPTH and no redirect, go to REQ: mem_req_o=1, mem_addr_o=fetch_pc.
- REQ, mem_ack_i=1, no redirect: push {mem_data_i, mem_addr_o+4}, fetch_pc+=4.
  - If the post-update count is below DEPTH, stay in REQ with the new address; this gives back-to-back fetch.
  - Otherwise go to IDLE with mem_req_o=0.
- At most one request is outstanding. A request is never aborted: mem_req_o and mem_addr_o hold until ack.
- Pop: when deq_valid_o & deq_ready_i & !redirect_i. Push and pop in the same cycle leave count unchanged.
- Redirect (redirect_i=1) has highest priority:
  - count becomes 0; pointers reset; the pop is ignored.
  - If in REQ with no ack this cycle: go to DRAIN, pending_pc=redirect_pc_i, keep the old request asserted.
  - If in REQ with ack this cycle: the acked word is discarded; fetch_pc=redirect_pc_i; issue at the new address next cycle (REQ).
  - If in IDLE: fetch_pc=redirect_pc_i, then REQ.
- DRAIN: on ack, discard the data, fetch_pc=pending_pc, go to REQ at the new address. A redirect during DRAIN overwrites pending_pc and stays in DRAIN.
- Full: no request is issued while count=DEPTH. The single outstanding request always has a free slot because it was issued only with count<DEPTH.
- Arithmetic: addresses wrap modulo 2^32 (32'hFFFF_FFFC+4 = 0). Pointers wrap modulo DEPTH.

## Timing
- During and after reset: mem_req_o=0, mem_addr_o=RESET_PC, deq_valid_o=0, deq_instr_o=0, deq_pc_o=0, level_o=0, state IDLE.
- First mem_req_o=1 appears in the 2nd cycle after rst_i falls (cycle 1 IDLE, cycle 2 REQ).
- Ack to deq_valid_o: 1 cycle. Data acked in cycle n is visible at the head in cycle n+1.
- Outputs deq_* are combinational from the FIFO head and count. level_o equals count.
- Redirect in cycle n: deq_valid_o=0 in cycle n+1.
  - First post-redirect request in cycle n+1 if not draining.
  - With a 0-wait memory, the target instruction is at the head in cycle n+2.
- Throughput: one instruction per cycle with a 0-wait memory when not full.
- Reset asserted mid-request: state returns to IDLE immediately; an ack arriving in the reset cycle is ignored.

## Test plan
- Reset, memory acks in the same cycle as req, deq_ready_i=1 → addresses 0,4,8,… on consecutive cycles; deq_pc_o=4,8,12,…; level_o stays ≤1.
- deq_ready_i=0, DEPTH=4 → exactly 4 acks; mem_req_o=0 with level_o=4. Raise deq_ready_i → pops in order and fetch resumes at 0x10.
- 3-cycle-latency memory, redirect_i=1 with redirect_pc_i=0x40 in the 1st wait cycle of a fetch to 0x8 → the 0x8 word is discarded on its ack; next mem_addr_o=0x40; no word from 0x8 is ever dequeued.
- Redirect in the same cycle as an ack and a pop, with level_o=2 → level_o=0 next cycle; mem_addr_o=target; the popped and acked words are dropped.
- Two redirects (0x100 then 0x200) during one DRAIN → the single refetch goes to 0x200.
- RESET_PC=32'hFFFF_FFF8, 0-wait memory → fetches at 0xFFFFFFF8, 0xFFFFFFFC, 0x0; deq_pc_o=0xFFFFFFFC, 0x0, 0x4.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Sequential-instruction prefetch queue: fetches over a req/ack memory port and
// buffers {instruction, PC+4} pairs for IF/ID, flushing on taken-branch redirects.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       redirect_i,
  input  logic [31:0]                redirect_pc_i,
  output logic                       mem_req_o,
  output logic [31:0]                mem_addr_o,
  input  logic                       mem_ack_i,
  input  logic [31:0]                mem_data_i,
  input  logic                       deq_ready_i,
  output logic                       deq_valid_o,
  output logic [31:0]                deq_instr_o,
  output logic [31:0]                deq_pc_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_e;

  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     pending_pc_q, pending_pc_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     instr_mem [DEPTH];
  logic [31:0]     pc_mem    [DEPTH];
  logic            push, pop;

  assign mem_req_o   = req_q;
  assign mem_addr_o  = fetch_pc_q;
  assign deq_valid_o = (count_q != '0);
  assign deq_instr_o = deq_valid_o ? instr_mem[rd_ptr_q] : '0;
  assign deq_pc_o    = deq_valid_o ? pc_mem[rd_ptr_q] : '0;
  assign level_o     = count_q;
  assign pop         = deq_valid_o & deq_ready_i & ~redirect_i;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    push         = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect_i) begin
          fetch_pc_d = redirect_pc_i;
          state_d    = REQ;
        end else if (count_q < FULL) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (redirect_i) begin
          // The outstanding request cannot be aborted; its data is dropped on arrival.
          if (mem_ack_i) begin
            fetch_pc_d = redirect_pc_i;
          end else begin
            pending_pc_d = redirect_pc_i;
            state_d      = DRAIN;
          end
        end else if (mem_ack_i) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          if ((count_q + CW'(1) - CW'(pop)) >= FULL) state_d = IDLE;
        end
      end
      DRAIN: begin
        if (mem_ack_i) begin
          fetch_pc_d = redirect_i ? redirect_pc_i : pending_pc_q;
          state_d    = REQ;
        end else if (redirect_i) begin
          pending_pc_d = redirect_pc_i;
        end
      end
      default: state_d = IDLE;
    endcase
    req_d = (state_d != IDLE);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage and pending target carry data only; their contents are qualified by count/state.
  always_ff @(posedge clk_i) begin
    pending_pc_q <= pending_pc_d;
    if (push) begin
      instr_mem[wr_ptr_q] <= mem_data_i;
      pc_mem[wr_ptr_q]    <= fetch_pc_q + 32'd4;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: queue-based reference model, variable-latency memory,
// directed scenarios with literal expectations, then randomized traffic.
module tb_instr_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_data_i = '0;
  logic        deq_ready_i = 1'b0;
  logic        deq_valid_o;
  logic [31:0] deq_instr_o;
  logic [31:0] deq_pc_o;
  logic [$clog2(DEPTH+1)-1:0] level_o;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
    .mem_data_i(mem_data_i), .deq_ready_i(deq_ready_i), .deq_valid_o(deq_valid_o),
    .deq_instr_o(deq_instr_o), .deq_pc_o(deq_pc_o), .level_o(level_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic [31:0] instr; logic [31:0] pc; } ent_t;

  int total = 0;
  int bad   = 0;

  // Reference model: queue contents plus the one outstanding request.
  ent_t        q[$];
  bit          m_req = 1'b0;
  bit          m_drain = 1'b0;
  logic [31:0] m_addr = RESET_PC;
  logic [31:0] m_pend = '0;

  // Memory latency generator and stimulus knobs.
  bit          armed = 1'b0;
  int          lat_left = 0;
  bit          k_rst = 1'b0;
  int          k_rst_pct = 0;
  int          k_lat_min = 0, k_lat_max = 0;
  int          k_ready_pct = 100;
  int          k_redir_pct = 0;
  bit          os_redir = 1'b0;
  logic [31:0] os_rpc = '0;
  logic [31:0] banned_pc = 32'h0000_0001;
  bit          banned_hit = 1'b0;
  logic [31:0] watch_addr = 32'h0000_0001;
  bit          watch_hit = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, input bit rd, input logic [31:0] rpc,
                              input bit ak, input bit rdy, input logic [31:0] data);
    int   sz0;
    bit   popv, ackv;
    ent_t e;
    if (r) begin
      m_req = 1'b0; m_drain = 1'b0; m_addr = RESET_PC; q.delete();
      return;
    end
    sz0  = q.size();
    popv = (sz0 > 0) && rdy && !rd;
    ackv = ak && m_req;
    if (rd) begin
      q.delete();
      if (m_req && !ackv) begin
        m_drain = 1'b1; m_pend = rpc;
      end else begin
        m_drain = 1'b0; m_req = 1'b1; m_addr = rpc;
      end
    end else begin
      if (popv) void'(q.pop_front());
      if (!m_req) begin
        m_req = (sz0 < DEPTH);
      end else if (ackv) begin
        if (m_drain) begin
          m_drain = 1'b0; m_addr = m_pend;
        end else begin
          e.instr = data; e.pc = m_addr + 32'd4;
          q.push_back(e);
          m_addr = m_addr + 32'd4;
          m_req  = (q.size() < DEPTH);
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] ei, ep;
    ei = (q.size() > 0) ? q[0].instr : 32'h0;
    ep = (q.size() > 0) ? q[0].pc : 32'h0;
    check("mem_req", 32'(mem_req_o), 32'(m_req));
    if (m_req) check("mem_addr", mem_addr_o, m_addr);
    check("deq_valid", 32'(deq_valid_o), 32'(q.size() > 0));
    check("deq_instr", deq_instr_o, ei);
    check("deq_pc", deq_pc_o, ep);
    check("level", 32'(level_o), 32'(q.size()));
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic step();
    bit r, rd, ak, rdy;
    logic [31:0] rpc, data;
    r   = k_rst || ($urandom_range(999) < 10 * k_rst_pct);
    rdy = ($urandom_range(99) < k_ready_pct);
    rd  = !r && (os_redir || ($urandom_range(99) < k_redir_pct));
    rpc = os_redir ? os_rpc : ($urandom() & 32'h0000_0FFC);
    os_redir = 1'b0;
    if (r) begin
      ak = 1'($urandom_range(1));
      armed = 1'b0;
    end else if (m_req) begin
      if (!armed) begin
        armed = 1'b1;
        lat_left = $urandom_range(k_lat_max, k_lat_min);
      end
      if (lat_left == 0) begin
        ak = 1'b1; armed = 1'b0;
      end else begin
        ak = 1'b0; lat_left--;
      end
    end else begin
      ak = 1'($urandom_range(1));
    end
    data = (ak && m_req) ? mem_word(m_addr) : $urandom();
    rst_i = r; redirect_i = rd; redirect_pc_i = rpc;
    mem_ack_i = ak; mem_data_i = data; deq_ready_i = rdy;
    if (deq_valid_o && rdy && !rd && !r && deq_pc_o == banned_pc) banned_hit = 1'b1;
    if (mem_req_o && mem_addr_o == watch_addr) watch_hit = 1'b1;
    model_update(r, rd, rpc, ak, rdy, data);
    @(posedge clk_i);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    k_rst = 1'b1;
    repeat (3) step();
    k_rst = 1'b0;
    check("rst_req", 32'(mem_req_o), 32'h0);
    check("rst_addr", mem_addr_o, RESET_PC);
    check("rst_valid", 32'(deq_valid_o), 32'h0);
    check("rst_instr", deq_instr_o, 32'h0);
    check("rst_pc", deq_pc_o, 32'h0);
    check("rst_level", 32'(level_o), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    #1;
    // Zero-wait memory, always ready: back-to-back fetch.
    k_lat_min = 0; k_lat_max = 0; k_ready_pct = 100;
    do_reset();
    step();
    check("t1_first_req", 32'(mem_req_o), 32'h1);
    check("t1_first_addr", mem_addr_o, 32'h0);
    step();
    check("t1_addr4", mem_addr_o, 32'h4);
    check("t1_pc4", deq_pc_o, 32'h4);
    check("t1_instr0", deq_instr_o, mem_word(32'h0));
    step();
    check("t1_addr8", mem_addr_o, 32'h8);
    check("t1_pc8", deq_pc_o, 32'h8);
    for (int i = 0; i < 8; i++) begin
      step();
      check("t1_level_le1", 32'(level_o <= 1), 32'h1);
    end

    // Stalled consumer fills the queue, then drains in order.
    k_ready_pct = 0;
    do_reset();
    step();
    repeat (4) step();
    check("t2_full_req", 32'(mem_req_o), 32'h0);
    check("t2_full_level", 32'(level_o), 32'h4);
    repeat (3) step();
    check("t2_hold_level", 32'(level_o), 32'h4);
    k_ready_pct = 100;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t2_pop_pc", deq_pc_o, 32'(4 * (i + 1)));
      check("t2_pop_instr", deq_instr_o, mem_word(32'(4 * i)));
      if (mem_req_o && !seen) begin
        check("t2_resume_addr", mem_addr_o, 32'h10);
        seen = 1'b1;
      end
      step();
    end
    check("t2_resumed", 32'(seen), 32'h1);

    // Redirect during the first wait cycle of a 3-wait fetch to 0x8.
    k_lat_min = 3; k_lat_max = 3;
    do_reset();
    for (int i = 0; i < 40 && !(mem_req_o && mem_addr_o == 32'h8); i++) step();
    check("t3_at8", mem_addr_o, 32'h8);
    banned_pc = 32'hC; banned_hit = 1'b0;
    os_redir = 1'b1; os_rpc = 32'h40;
    step();
    check("t3_hold_req", 32'(mem_req_o), 32'h1);
    check("t3_hold_addr", mem_addr_o, 32'h8);
    check("t3_flush_valid", 32'(deq_valid_o), 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (mem_req_o && mem_addr_o != 32'h8) begin
        check("t3_target_addr", mem_addr_o, 32'h40);
        seen = 1'b1;
      end
    end
    check("t3_refetched", 32'(seen), 32'h1);
    repeat (12) step();
    check("t3_no_stale_word", 32'(banned_hit), 32'h0);
    banned_pc = 32'h0000_0001;

    // Redirect coinciding with an ack and a pop, two entries buffered.
    k_lat_min = 0; k_lat_max = 0; k_ready_pct = 0;
    do_reset();
    step(); step(); step();
    check("t4_level2", 32'(level_o), 32'h2);
    check("t4_addr8", mem_addr_o, 32'h8);
    k_ready_pct = 100;
    os_redir = 1'b1; os_rpc = 32'h80;
    step();
    check("t4_level0", 32'(level_o), 32'h0);
    check("t4_valid0", 32'(deq_valid_o), 32'h0);
    check("t4_req", 32'(mem_req_o), 32'h1);
    check("t4_addr", mem_addr_o, 32'h80);
    step();
    check("t4_head_pc", deq_pc_o, 32'h84);
    check("t4_head_instr", deq_instr_o, mem_word(32'h80));

    // Two redirects while draining one slow request.
    k_lat_min = 4; k_lat_max = 4;
    do_reset();
    step();
    watch_addr = 32'h100; watch_hit = 1'b0;
    os_redir = 1'b1; os_rpc = 32'h100;
    step();
    check("t5_drain_addr", mem_addr_o, 32'h0);
    os_redir = 1'b1; os_rpc = 32'h200;
    step();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (mem_req_o && mem_addr_o != 32'h0) begin
        check("t5_refetch_addr", mem_addr_o, 32'h200);
        seen = 1'b1;
      end
    end
    check("t5_refetched", 32'(seen), 32'h1);
    check("t5_no_0x100", 32'(watch_hit), 32'h0);
    watch_addr = 32'h0000_0001;

    // Address wrap across 2^32.
    k_lat_min = 0; k_lat_max = 0;
    do_reset();
    step();
    os_redir = 1'b1; os_rpc = 32'hFFFF_FFF8;
    step();
    check("t6_addr_fff8", mem_addr_o, 32'hFFFF_FFF8);
    step();
    check("t6_addr_fffc", mem_addr_o, 32'hFFFF_FFFC);
    check("t6_pc_fffc", deq_pc_o, 32'hFFFF_FFFC);
    step();
    check("t6_addr_0", mem_addr_o, 32'h0);
    check("t6_pc_0", deq_pc_o, 32'h0);
    step();
    check("t6_addr_4", mem_addr_o, 32'h4);
    check("t6_pc_4", deq_pc_o, 32'h4);
    check("t6_instr", deq_instr_o, mem_word(32'h0));

    // Randomized traffic.
    k_lat_min = 0; k_lat_max = 3; k_ready_pct = 70; k_redir_pct = 5; k_rst_pct = 1;
    repeat (3000) step();
    k_redir_pct = 0; k_rst_pct = 0; k_ready_pct = 20;
    repeat (300) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
